// File: rtl/adder_pkg.sv
// Shared encodings and flag bundle for the pipelined add/sub unit.
package adder_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/adder_slice.sv
// W-bit ripple adder slice built from full adders; combinational, no handshake.
// Also exposes the carry into the slice MSB so the top slice can derive signed overflow.
module adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);

    logic [W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        fulladder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_c[i]),
            .sum  (sum[i]),
            .cout (w_c[i+1])
        );
    end

    assign cout     = w_c[W];
    assign c_msb_in = w_c[W-1];

endmodule

// File: rtl/fulladder.sv
// One-bit full adder, the basic cell of every slice ripple chain; purely combinational.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/sub with NZCV flags, one WIDTH/STAGES slice per stage; latency STAGES cycles.
// Whole pipe freezes when the output is valid and not taken; in_ready = !out_valid | out_ready.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int W = WIDTH / STAGES;

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;
    alu_flags_t       w_flags;

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    // Subtraction is a + ~b + !cin, so a borrow-in of 1 removes the +1.
    assign w_b_eff = (op == ADD) ? b : ~b;
    assign w_c0    = (op == SUB) ? !cin : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SMW = (k + 1) * W;

        logic [W-1:0]   w_sa;
        logic [W-1:0]   w_sb;
        logic [W-1:0]   w_ss;
        logic           w_ci;
        logic           w_co;
        logic           w_cm;
        logic           w_vld_in;
        logic           w_z_in;
        logic [SMW-1:0] w_sum_nxt;

        logic           r_vld;
        logic           r_carry;
        logic           r_z;
        logic [SMW-1:0] r_sum;

        if (k == 0) begin : g_head
            assign w_sa      = a[W-1:0];
            assign w_sb      = w_b_eff[W-1:0];
            assign w_ci      = w_c0;
            assign w_vld_in  = in_valid;
            assign w_z_in    = 1'b1;
            assign w_sum_nxt = w_ss;
        end else begin : g_body
            assign w_sa      = g_stage[k-1].g_skew.r_a[W-1:0];
            assign w_sb      = g_stage[k-1].g_skew.r_b[W-1:0];
            assign w_ci      = g_stage[k-1].r_carry;
            assign w_vld_in  = g_stage[k-1].r_vld;
            assign w_z_in    = g_stage[k-1].r_z;
            assign w_sum_nxt = {w_ss, g_stage[k-1].r_sum};
        end

        adder_slice #(
            .W (W)
        ) u_slice (
            .a        (w_sa),
            .b        (w_sb),
            .cin      (w_ci),
            .sum      (w_ss),
            .cout     (w_co),
            .c_msb_in (w_cm)
        );

        // Bubbles shift like real beats; only the valid bit tells them apart.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld   <= 1'b0;
                r_carry <= 1'b0;
                r_z     <= 1'b0;
                r_sum   <= '0;
            end else if (w_advance) begin
                r_vld   <= w_vld_in;
                r_carry <= w_co;
                r_z     <= w_z_in && (w_ss == '0);
                r_sum   <= w_sum_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            localparam int SKW = WIDTH - (k + 1) * W;

            logic [SKW-1:0] w_a_nxt;
            logic [SKW-1:0] w_b_nxt;
            logic [SKW-1:0] r_a;
            logic [SKW-1:0] r_b;

            if (k == 0) begin : g_src_in
                assign w_a_nxt = a[WIDTH-1:W];
                assign w_b_nxt = w_b_eff[WIDTH-1:W];
            end else begin : g_src_prev
                assign w_a_nxt = g_stage[k-1].g_skew.r_a[SKW+W-1:W];
                assign w_b_nxt = g_stage[k-1].g_skew.r_b[SKW+W-1:W];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_advance) begin
                    r_a <= w_a_nxt;
                    r_b <= w_b_nxt;
                end
            end
        end

        if (k == STAGES - 1) begin : g_tail
            logic r_v;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v <= 1'b0;
                end else if (w_advance) begin
                    r_v <= w_cm ^ w_co;
                end
            end
        end else begin : g_mid
            logic w_unused_cm;
            assign w_unused_cm = w_cm;
        end
    end

    assign out_valid = g_stage[STAGES-1].r_vld;
    assign sum       = g_stage[STAGES-1].r_sum;

    assign w_flags.n = g_stage[STAGES-1].r_sum[WIDTH-1];
    assign w_flags.z = g_stage[STAGES-1].r_z;
    assign w_flags.c = g_stage[STAGES-1].r_carry;
    assign w_flags.v = g_stage[STAGES-1].g_tail.r_v;

    assign flag_n = w_flags.n;
    assign flag_z = w_flags.z;
    assign flag_c = w_flags.c;
    assign flag_v = w_flags.v;

endmodule
